// File: rtl/bt656_pkg.sv
// Shared BT.656 decoder types: control states, TRS byte values and XY protection check.
// No timing of its own; imported by the matcher and the top.
package bt656_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    HDR1,
    HDR2,
    HDR3,
    ACTIVE,
    BLANK
  } state_t;

  localparam logic [7:0] TRS_FF = 8'hFF;
  localparam logic [7:0] TRS_00 = 8'h00;

  // XY carries F/V/H plus four Hamming-style protection bits derived from them.
  function automatic logic trs_prot_ok(input logic [7:0] xy);
    logic f, v, h;
    f = xy[6];
    v = xy[5];
    h = xy[4];
    return xy[7] && (xy[3:0] == {v ^ h, f ^ h, f ^ v, f ^ v ^ h});
  endfunction

endpackage

// File: rtl/bt656_trs_detect.sv
// FF 00 00 XY header matcher; hit/err are combinational while the XY byte is on the bus.
// Free-running on the byte stream; held idle while en is low.
module bt656_trs_detect
  import bt656_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] td_data,
  output logic       trs_hit,
  output logic       f,
  output logic       v,
  output logic       h,
  output logic       err
);

  state_t hdr;
  logic   at_xy;
  logic   prot_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr <= IDLE;
    end else if (!en) begin
      hdr <= IDLE;
    end else begin
      case (hdr)
        IDLE: hdr <= SEARCH;
        HDR1: begin
          if (td_data == TRS_00) hdr <= HDR2;
          else if (td_data != TRS_FF) hdr <= SEARCH;
        end
        HDR2:    hdr <= (td_data == TRS_00) ? HDR3 : SEARCH;
        HDR3:    hdr <= SEARCH;
        default: if (td_data == TRS_FF) hdr <= HDR1;
      endcase
    end
  end

  assign at_xy   = en && (hdr == HDR3);
  assign prot_ok = trs_prot_ok(td_data);
  assign trs_hit = at_xy && prot_ok;
  assign err     = at_xy && !prot_ok;
  assign f       = td_data[6];
  assign v       = td_data[5];
  assign h       = td_data[4];

endmodule

// File: rtl/bt656_decoder.sv
// BT.656 stream decoder: TRS lock, F/V status and Cb/Y0/Cr/Y1 pair extraction with coordinates.
// Pair out 1 cycle after Y1, status 1 cycle after XY; no backpressure, decoding gated by cfg_done.
module bt656_decoder
  import bt656_pkg::*;
#(
  parameter int ACTIVE_PAIRS = 360,
  parameter int LINE_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_done,
  input  logic [7:0]        td_data,
  output logic              pair_valid,
  output logic [7:0]        cb,
  output logic [7:0]        y0,
  output logic [7:0]        cr,
  output logic [7:0]        y1,
  output logic [8:0]        pair_x,
  output logic [LINE_W-1:0] line_y,
  output logic              field,
  output logic              vblank,
  output logic              frame_start,
  output logic              code_err
);

  localparam logic [8:0]        PAIR_LIM = 9'(ACTIVE_PAIRS);
  localparam logic [LINE_W-1:0] LINE_MAX = '1;

  state_t     state;
  logic [1:0] phase;
  logic [8:0] pair_cnt;
  logic [7:0] cb_q, y0_q, cr_q;
  logic       line_open;
  logic       prev_v;
  logic       trs_hit, trs_f, trs_v, trs_h, trs_err;

  bt656_trs_detect u_trs (
    .clk     (clk),
    .rst     (rst),
    .en      (cfg_done),
    .td_data (td_data),
    .trs_hit (trs_hit),
    .f       (trs_f),
    .v       (trs_v),
    .h       (trs_h),
    .err     (trs_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;  phase <= '0;  pair_cnt <= '0;
      cb_q <= '0;  y0_q <= '0;  cr_q <= '0;
      line_open <= 1'b0;  prev_v <= 1'b0;
      pair_valid <= 1'b0;  cb <= '0;  y0 <= '0;  cr <= '0;  y1 <= '0;
      pair_x <= '0;  line_y <= '0;  field <= 1'b0;  vblank <= 1'b0;
      frame_start <= 1'b0;  code_err <= 1'b0;
    end else if (!cfg_done) begin
      state <= IDLE;  phase <= '0;  pair_cnt <= '0;
      cb_q <= '0;  y0_q <= '0;  cr_q <= '0;
      line_open <= 1'b0;  prev_v <= 1'b0;
      pair_valid <= 1'b0;  cb <= '0;  y0 <= '0;  cr <= '0;  y1 <= '0;
      pair_x <= '0;  line_y <= '0;  field <= 1'b0;  vblank <= 1'b0;
      frame_start <= 1'b0;  code_err <= 1'b0;
    end else begin
      pair_valid  <= 1'b0;
      frame_start <= 1'b0;
      code_err    <= 1'b0;
      case (state)
        IDLE: state <= SEARCH;
        // Header bytes are tracked by the matcher; this state only waits for its verdict.
        SEARCH: begin
          if (trs_err) begin
            code_err <= 1'b1;
            state    <= BLANK;
          end else if (trs_hit) begin
            field     <= trs_f;
            vblank    <= trs_v;
            prev_v    <= trs_v;
            line_open <= 1'b0;
            if (trs_v) line_y <= '0;
            else if (trs_h && line_open && line_y != LINE_MAX) line_y <= line_y + LINE_W'(1);
            if (!trs_h && !trs_v) begin
              state       <= ACTIVE;
              phase       <= '0;
              pair_cnt    <= '0;
              pair_x      <= '0;
              line_open   <= 1'b1;
              frame_start <= !trs_f && prev_v;
            end else begin
              state <= BLANK;
            end
          end
        end
        ACTIVE: begin
          if (td_data == TRS_FF) begin
            state <= SEARCH;
            phase <= '0;
            if (phase != 2'd0) code_err <= 1'b1;
          end else begin
            case (phase)
              2'd0: cb_q <= td_data;
              2'd1: y0_q <= td_data;
              2'd2: cr_q <= td_data;
              default: begin
                // Pairs beyond the nominal line width are dropped without a flag.
                if (pair_cnt < PAIR_LIM) begin
                  cb         <= cb_q;
                  y0         <= y0_q;
                  cr         <= cr_q;
                  y1         <= td_data;
                  pair_x     <= pair_cnt;
                  pair_valid <= 1'b1;
                  pair_cnt   <= pair_cnt + 9'd1;
                end
              end
            endcase
            phase <= phase + 2'd1;
          end
        end
        BLANK:   if (td_data == TRS_FF) state <= SEARCH;
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_bt656_decoder.sv
// Bench for bt656_decoder: byte-level stimulus run in lockstep with a behavioural stream model.
module tb_bt656_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_done = 1'b0;
  logic [7:0] td_data = 8'h00;

  logic       pair_valid;
  logic [7:0] cb, y0, cr, y1;
  logic [8:0] pair_x;
  logic [9:0] line_y;
  logic       field, vblank, frame_start, code_err;

  bt656_decoder #(.ACTIVE_PAIRS(360), .LINE_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_done    (cfg_done),
    .td_data     (td_data),
    .pair_valid  (pair_valid),
    .cb          (cb),
    .y0          (y0),
    .cr          (cr),
    .y1          (y1),
    .pair_x      (pair_x),
    .line_y      (line_y),
    .field       (field),
    .vblank      (vblank),
    .frame_start (frame_start),
    .code_err    (code_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          n_pv, n_ce, n_fs, n_div;
  logic [8:0]  last_px;
  logic [31:0] last_pix;
  logic [55:0] div_got, div_want;

  // Reference model: expected registered outputs plus stream-level bookkeeping.
  logic       e_pv, e_field, e_vb, e_fs, e_ce;
  logic [7:0] e_cb, e_y0, e_cr, e_y1;
  logic [8:0] e_px;
  logic [9:0] e_ly;
  bit         m_on, m_active, m_open, m_prev_v;
  int         m_hdr, m_phase, m_pairs, m_npv, m_nce;
  logic [7:0] m_q [4];

  logic [7:0] vxy [8] = '{8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1};

  function automatic logic [55:0] obs_vec();
    return {pair_valid, cb, y0, cr, y1, pair_x, line_y, field, vblank, frame_start, code_err};
  endfunction

  function automatic logic [55:0] exp_vec();
    return {e_pv, e_cb, e_y0, e_cr, e_y1, e_px, e_ly, e_field, e_vb, e_fs, e_ce};
  endfunction

  task automatic model_clear();
    m_on = 0; m_hdr = 0; m_active = 0; m_open = 0; m_prev_v = 0; m_phase = 0; m_pairs = 0;
    e_pv = 0; e_cb = 0; e_y0 = 0; e_cr = 0; e_y1 = 0; e_px = 0; e_ly = 0;
    e_field = 0; e_vb = 0; e_fs = 0; e_ce = 0;
  endtask

  task automatic model_step(input logic [7:0] b);
    logic f_, v_, h_;
    logic [7:0] want;
    e_pv = 0; e_fs = 0; e_ce = 0;
    if (!rst || !cfg_done) begin
      model_clear();
      return;
    end
    if (!m_on) begin
      m_on = 1;
      return;
    end
    case (m_hdr)
      3: begin
        m_hdr = 0;
        m_active = 0;
        f_ = b[6]; v_ = b[5]; h_ = b[4];
        want = {1'b1, f_, v_, h_, v_ ^ h_, f_ ^ h_, f_ ^ v_, f_ ^ v_ ^ h_};
        if (b !== want) begin
          e_ce = 1; m_nce++;
        end else begin
          e_field = f_; e_vb = v_;
          if (v_) e_ly = 0;
          else if (h_ && m_open && e_ly != 10'h3FF) e_ly = e_ly + 10'd1;
          m_open = 0;
          if (!h_ && !v_) begin
            m_active = 1; m_phase = 0; m_pairs = 0; e_px = 0; m_open = 1;
            if (!f_ && m_prev_v) e_fs = 1;
          end
          m_prev_v = v_;
        end
      end
      2: m_hdr = (b == 8'h00) ? 3 : 0;
      1: m_hdr = (b == 8'h00) ? 2 : ((b == 8'hFF) ? 1 : 0);
      default: begin
        if (b == 8'hFF) begin
          m_hdr = 1;
          if (m_active && m_phase != 0) begin e_ce = 1; m_nce++; end
          m_active = 0;
        end else if (m_active) begin
          m_q[m_phase] = b;
          if (m_phase == 3) begin
            if (m_pairs < 360) begin
              e_pv = 1; m_npv++;
              e_cb = m_q[0]; e_y0 = m_q[1]; e_cr = m_q[2]; e_y1 = b;
              e_px = 9'(m_pairs);
              m_pairs++;
            end
            m_phase = 0;
          end else begin
            m_phase++;
          end
        end
      end
    endcase
  endtask

  task automatic clear_counts();
    n_pv = 0; n_ce = 0; n_fs = 0; n_div = 0; m_npv = 0; m_nce = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    td_data = b;
    @(posedge clk);
    #1;
    model_step(b);
    if (pair_valid) begin n_pv++; last_px = pair_x; last_pix = {cb, y0, cr, y1}; end
    if (code_err) n_ce++;
    if (frame_start) n_fs++;
    if (obs_vec() !== exp_vec()) begin
      if (n_div == 0) begin div_got = obs_vec(); div_want = exp_vec(); end
      n_div++;
    end
  endtask

  task automatic send_trs(input logic [7:0] xy);
    send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00); send_byte(xy);
  endtask

  task automatic send_pairs(input int n, input bit fixed);
    for (int i = 0; i < n; i++) begin
      if (fixed) begin
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
      end else begin
        for (int k = 0; k < 4; k++) send_byte(8'($urandom_range(1, 254)));
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_vec() !== 56'd0) begin
      $display("FAIL reset_outputs: got %h want 0", obs_vec()); errors++;
    end
    rst = 1'b1;
    model_clear();
    clear_counts();
    send_byte(8'h00);
    checks++;
    if (obs_vec() !== 56'd0) begin
      $display("FAIL post_reset_idle: got %h want 0", obs_vec()); errors++;
    end
  endtask

  task automatic test_cfg_gate();
    clear_counts();
    send_trs(8'h80); send_pairs(8, 0); send_trs(8'h9D);
    send_trs(8'h80); send_pairs(2, 0);
    checks++;
    if (n_pv !== 0) begin $display("FAIL cfg_low_pairs: got %0d want 0", n_pv); errors++; end
    cfg_done = 1'b1;
    send_pairs(3, 0);
    checks++;
    if (n_pv !== 0) begin $display("FAIL cfg_midline_pairs: got %0d want 0", n_pv); errors++; end
    send_trs(8'h9D); send_trs(8'h80); send_pairs(2, 0);
    checks++;
    if (n_pv !== 2 || last_px !== 9'd1) begin
      $display("FAIL cfg_after_sav: pairs %0d px %0d want 2 and 1", n_pv, last_px); errors++;
    end
    checks++;
    if (n_div !== 0) begin
      $display("FAIL cfg_model: %0d divergent cycles, got %h want %h", n_div, div_got, div_want); errors++;
    end
  endtask

  task automatic test_line();
    clear_counts();
    send_trs(8'hB6); send_trs(8'h80);
    send_pairs(360, 1);
    checks++;
    if (n_pv !== 360 || last_px !== 9'd359) begin
      $display("FAIL line_pairs: count %0d last_px %0d want 360 and 359", n_pv, last_px); errors++;
    end
    checks++;
    if (last_pix !== 32'h10203040) begin
      $display("FAIL line_pixels: got %h want 10203040", last_pix); errors++;
    end
    send_trs(8'h9D);
    checks++;
    if (line_y !== 10'd1) begin $display("FAIL line_eav_inc: got %0d want 1", line_y); errors++; end
    checks++;
    if (n_div !== 0) begin
      $display("FAIL line_model: %0d divergent cycles, got %h want %h", n_div, div_got, div_want); errors++;
    end
  endtask

  task automatic test_field();
    clear_counts();
    send_trs(8'hB6); send_trs(8'hAB); send_trs(8'h80);
    checks++;
    if (n_fs !== 1 || line_y !== 10'd0 || field !== 1'b0) begin
      $display("FAIL field0_start: fs %0d line %0d field %0d want 1 0 0", n_fs, line_y, field); errors++;
    end
    send_pairs(4, 0); send_trs(8'h9D);
    n_fs = 0;
    send_trs(8'hF1); send_trs(8'hC7);
    checks++;
    if (n_fs !== 0 || field !== 1'b1 || vblank !== 1'b0) begin
      $display("FAIL field1_no_start: fs %0d field %0d vblank %0d want 0 1 0", n_fs, field, vblank); errors++;
    end
    checks++;
    if (n_div !== 0) begin
      $display("FAIL field_model: %0d divergent cycles, got %h want %h", n_div, div_got, div_want); errors++;
    end
  endtask

  task automatic test_bad_xy();
    clear_counts();
    send_trs(8'h81);
    checks++;
    if (n_ce !== 1 || field !== 1'b1) begin
      $display("FAIL bad_xy_err: code_err %0d field %0d want 1 1", n_ce, field); errors++;
    end
    send_pairs(8, 0);
    checks++;
    if (n_pv !== 0) begin $display("FAIL bad_xy_blank: got %0d pairs want 0", n_pv); errors++; end
    send_trs(8'h80); send_pairs(2, 0);
    checks++;
    if (n_pv !== 2) begin $display("FAIL bad_xy_resume: got %0d pairs want 2", n_pv); errors++; end
    checks++;
    if (n_div !== 0) begin
      $display("FAIL bad_xy_model: %0d divergent cycles, got %h want %h", n_div, div_got, div_want); errors++;
    end
  endtask

  task automatic test_truncated();
    clear_counts();
    send_trs(8'hB6); send_trs(8'h80);
    send_pairs(3, 0);
    send_byte(8'h55); send_byte(8'h66);
    send_trs(8'h9D);
    checks++;
    if (n_ce !== 1 || n_pv !== 3 || line_y !== 10'd1) begin
      $display("FAIL truncated: err %0d pairs %0d line %0d want 1 3 1", n_ce, n_pv, line_y); errors++;
    end
    checks++;
    if (n_div !== 0) begin
      $display("FAIL truncated_model: %0d divergent cycles, got %h want %h", n_div, div_got, div_want); errors++;
    end
  endtask

  task automatic test_overflow();
    clear_counts();
    send_trs(8'h80);
    send_pairs(370, 0);
    checks++;
    if (n_pv !== 360 || last_px !== 9'd359) begin
      $display("FAIL overflow_drop: count %0d last_px %0d want 360 and 359", n_pv, last_px); errors++;
    end
    send_trs(8'h9D);
    checks++;
    if (n_div !== 0) begin
      $display("FAIL overflow_model: %0d divergent cycles, got %h want %h", n_div, div_got, div_want); errors++;
    end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    send_trs(8'hB6); send_trs(8'h80);
    send_pairs(5, 0);
    send_byte(8'h11); send_byte(8'h22);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 56'd0) begin
      $display("FAIL reset_async: got %h want 0", obs_vec()); errors++;
    end
    model_clear();
    repeat (3) send_byte(8'h33);
    rst = 1'b1;
    send_pairs(2, 0);
    checks++;
    if (n_pv !== 5) begin $display("FAIL reset_no_early: got %0d pairs want 5", n_pv); errors++; end
    send_trs(8'h80); send_pairs(3, 0);
    checks++;
    if (n_pv !== 8) begin $display("FAIL reset_resume: got %0d pairs want 8", n_pv); errors++; end
    checks++;
    if (n_div !== 0) begin
      $display("FAIL reset_model: %0d divergent cycles, got %h want %h", n_div, div_got, div_want); errors++;
    end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] xy;
    clear_counts();
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 15) == 0) begin
        cfg_done = 1'b0;
        repeat (3) send_byte(8'($urandom_range(1, 254)));
        cfg_done = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) begin
        send_byte(8'hFF); send_byte(8'($urandom_range(1, 254)));
      end
      if ($urandom_range(0, 5) == 0) send_byte(8'hFF);
      r = $urandom_range(0, 11);
      if (r < 8) xy = vxy[r];
      else if (r < 10) xy = 8'h80;
      else xy = 8'($urandom_range(0, 255));
      send_trs(xy);
      send_pairs($urandom_range(0, 10), 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) send_byte(8'($urandom_range(1, 254)));
      end
    end
    checks++;
    if (n_div !== 0) begin
      $display("FAIL random_model: %0d divergent cycles, got %h want %h", n_div, div_got, div_want); errors++;
    end
    checks++;
    if (n_pv !== m_npv || n_ce !== m_nce) begin
      $display("FAIL random_counts: pairs %0d err %0d want %0d %0d", n_pv, n_ce, m_npv, m_nce); errors++;
    end
    checks++;
    if (n_pv == 0) begin $display("FAIL random_activity: got 0 pairs want some"); errors++; end
  endtask

  initial begin
    model_clear();
    clear_counts();
    last_px = '0;
    last_pix = '0;
    div_got = '0;
    div_want = '0;
    test_reset();
    test_cfg_gate();
    test_line();
    test_field();
    test_bad_xy();
    test_truncated();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
